// File: rtl/mem_arb_pkg.sv
// Shared definitions for the single-port memory arbiter.
package mem_arb_pkg;

    // Default word width; the value comes from the pipeline's opcode definitions.
    localparam int unsigned ARB_WORD_SIZE = 16;
    // Default number of cycles each access holds the memory port.
    localparam int unsigned ARB_MEM_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access. Data has
// priority from idle; at a completion edge the other pending requester is
// granted directly, so the two alternate and neither starves.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = mem_arb_pkg::ARB_WORD_SIZE,
    parameter int unsigned MEM_LATENCY = mem_arb_pkg::ARB_MEM_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_inst,
    output logic                 i_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    output logic                 stall_if,
    output logic                 stall_mem,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data
);

    localparam int unsigned CntW = $clog2(MEM_LATENCY) + 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

    arb_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] i_inst_q, d_rdata_q;
    logic                 grant_i, grant_d;
    logic                 busy, done;

    // State, counter, captured request and latched read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_inst_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (i_done) begin
                i_inst_q <= data;
            end
            if (d_done && !we_q) begin
                d_rdata_q <= data;
            end
        end
    end

    // Next-state: grant from idle, count down while busy, hand over at completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_req) begin
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end
            end
            // The just-served requester's req is stale here, so only the other is considered.
            I_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (d_req) begin
                    grant_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            D_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_d) begin
            state_d = D_BUSY;
            cnt_d   = CntLoad;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
        end else if (grant_i) begin
            state_d = I_BUSY;
            cnt_d   = CntLoad;
            addr_d  = i_addr;
            we_d    = 1'b0;
        end
    end

    // Outputs: strobes while busy, done on the last busy cycle, read data passthrough.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = busy && (cnt_q == '0);
        readM     = busy && !we_q;
        writeM    = (state_q == D_BUSY) && we_q;
        address   = addr_q;
        i_done    = (state_q == I_BUSY) && done;
        d_done    = (state_q == D_BUSY) && done;
        i_inst    = i_done ? data : i_inst_q;
        d_rdata   = (d_done && !we_q) ? data : d_rdata_q;
        stall_if  = i_req && !i_done;
        stall_mem = d_req && !d_done;
    end

    assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned W   = ARB_WORD_SIZE;
    localparam int          LAT = ARB_MEM_LATENCY;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_req, d_req, d_we;
    logic [W-1:0] i_addr, d_addr, d_wdata;
    logic [W-1:0] i_inst, d_rdata, address;
    logic         i_done, d_done, stall_if, stall_mem, readM, writeM;
    wire  [W-1:0] data;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_inst   (i_inst),
        .i_done   (i_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .readM    (readM),
        .writeM   (writeM),
        .address  (address),
        .data     (data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] seed_word(input logic [7:0] a);
        return {a, ~a} ^ 16'h5A3C;
    endfunction

    // Memory: combinational read data on the bus during readM, write on the strobe.
    logic [W-1:0] mem [256];
    bit           mem_init = 1'b0;
    assign data = readM ? mem[address[7:0]] : {W{1'bz}};
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= seed_word(k[7:0]);
            mem_init <= 1'b1;
        end else if (writeM) begin
            mem[address[7:0]] <= data;
        end
    end

    // Transaction model: owner 0 none, 1 fetch, 2 data; elapsed counts busy cycles from 1.
    logic [W-1:0] ref_mem [256];
    int           owner, elapsed;
    logic [W-1:0] m_addr, m_wdata, last_inst, last_rdata;
    logic         m_we;
    bit           model_valid = 1'b0;
    bit           i_comp, d_comp;
    logic         s_rst, s_i_req, s_d_req, s_d_we;
    logic [W-1:0] s_i_addr, s_d_addr, s_d_wdata;
    logic         obs_i_done, obs_d_done, obs_readM;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic         busy, done, e_rd, e_wr, e_idone, e_ddone;
        logic [W-1:0] word;
        busy     = (owner != 0);
        done     = busy && (elapsed == LAT);
        e_wr     = (owner == 2) && m_we;
        e_rd     = busy && !e_wr;
        e_idone  = done && (owner == 1);
        e_ddone  = done && (owner == 2);
        word     = ref_mem[m_addr[7:0]];
        check_eq("readM", readM, e_rd);
        check_eq("writeM", writeM, e_wr);
        check_eq("address", address, m_addr);
        check_eq("i_done", i_done, e_idone);
        check_eq("d_done", d_done, e_ddone);
        check_eq("i_inst", i_inst, e_idone ? word : last_inst);
        check_eq("d_rdata", d_rdata, (e_ddone && !m_we) ? word : last_rdata);
        check_eq("stall_if", stall_if, i_req && !e_idone);
        check_eq("stall_mem", stall_mem, d_req && !e_ddone);
        if (e_wr) check_eq("bus_wdata", data, m_wdata);
    endtask

    task automatic grant(input int who);
        owner   = who;
        elapsed = 1;
        if (who == 2) begin
            m_addr  = s_d_addr;
            m_we    = s_d_we;
            m_wdata = s_d_wdata;
        end else begin
            m_addr = s_i_addr;
            m_we   = 1'b0;
        end
    endtask

    task automatic model_edge();
        i_comp = 1'b0;
        d_comp = 1'b0;
        if (!s_rst) begin
            owner = 0; elapsed = 0; m_we = 1'b0; m_addr = '0;
            last_inst = '0; last_rdata = '0;
            model_valid = 1'b1;
        end else if (owner != 0 && elapsed < LAT) begin
            elapsed++;
        end else if (owner != 0) begin
            if (owner == 1) begin
                last_inst = ref_mem[m_addr[7:0]];
                i_comp = 1'b1;
                if (s_d_req) grant(2); else owner = 0;
            end else begin
                if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
                else last_rdata = ref_mem[m_addr[7:0]];
                d_comp = 1'b1;
                if (s_i_req) grant(1); else owner = 0;
            end
        end else if (s_d_req) begin
            grant(2);
        end else if (s_i_req) begin
            grant(1);
        end
    endtask

    // One clock: check at the falling edge, then advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        if (model_valid) check_outputs();
        obs_i_done = i_done;
        obs_d_done = d_done;
        obs_readM  = readM;
        s_rst = reset_n; s_i_req = i_req; s_d_req = d_req; s_d_we = d_we;
        s_i_addr = i_addr; s_d_addr = d_addr; s_d_wdata = d_wdata;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [W-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Requesters hold req until done; inputs are scrambled while their access is in flight.
    task automatic drive_random(input int pct);
        if (i_comp) i_req = 1'b0;
        if (d_comp) d_req = 1'b0;
        if (i_req && owner == 1) i_addr = W'($urandom);
        if (d_req && owner == 2) begin
            d_addr = W'($urandom); d_we = ($urandom_range(0, 1) == 1); d_wdata = W'($urandom);
        end
        if (!i_req && $urandom_range(0, 99) < pct) begin
            i_req = 1'b1; i_addr = pick_addr();
        end
        if (!d_req && $urandom_range(0, 99) < pct) begin
            d_req = 1'b1; d_addr = pick_addr();
            d_we = ($urandom_range(0, 1) == 1); d_wdata = W'($urandom);
        end
    endtask

    initial begin
        int n, first, last, dones;
        for (int k = 0; k < 256; k++) ref_mem[k] = seed_word(k[7:0]);
        reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Single fetch: done observed LAT+1 falling edges after the request appears.
        i_req = 1'b1; i_addr = 16'h0010;
        n = 0;
        do begin step(); n++; end while (!obs_i_done && n < 20);
        check_eq("fetch_done_step", n, LAT + 1);
        i_req = 1'b0;
        repeat (2) step();

        // Simultaneous write and fetch: fetch follows the write with no idle cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
        i_req = 1'b1; i_addr = 16'h0020;
        n = 0; first = 0;
        do begin
            step(); n++;
            if (obs_d_done) first = n;
            if (d_comp) d_req = 1'b0;
        end while (!obs_i_done && n < 20);
        check_eq("write_done_step", first, LAT + 1);
        check_eq("fetch_after_write_step", n, 2 * LAT + 1);
        i_req = 1'b0;
        repeat (2) step();

        // Continuous fetches 0,1,2: one idle cycle between consecutive accesses.
        i_req = 1'b1; i_addr = '0;
        n = 0; dones = 0; first = 0; last = 0;
        while (dones < 3 && n < 40) begin
            step(); n++;
            if (obs_i_done) begin
                if (dones > 0) check_eq("fetch_spacing", n - last, LAT + 1);
                last = n; dones++;
                i_addr = i_addr + 16'd1;
            end
        end
        check_eq("fetch_count", dones, 3);
        i_req = 1'b0;
        repeat (2) step();

        // Saturated then mixed random traffic.
        for (int c = 0; c < 60; c++) begin step(); drive_random(100); end
        for (int c = 0; c < 500; c++) begin step(); drive_random(30); end
        i_req = 1'b0; d_req = 1'b0;
        n = 0;
        while (owner != 0 && n < 20) begin step(); n++; if (i_comp) i_req = 1'b0; if (d_comp) d_req = 1'b0; end
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) step();

        // Reset during the last busy cycle of a read aborts it.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0033;
        n = 0;
        while (!(owner == 2 && elapsed == ((LAT < 2) ? LAT : 2)) && n < 20) begin step(); n++; end
        check_eq("abort_reached", (owner == 2) ? 1 : 0, 1);
        reset_n = 1'b0; d_req = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check_eq("abort_readM", obs_readM, 1'b0);
        check_eq("abort_d_done", obs_d_done, 1'b0);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
